// File: rtl/mult_datapath_if.sv
// Control/result bundle between the multiplier sequencer (master) and the
// shift-add datapath (slave).
interface mult_datapath_if #(
    parameter int N = 4
);
    logic           reset;
    logic           add;
    logic           shift;
    logic           ready;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           Q0;
    logic [2*N-1:0] product;
    logic           product_valid;
    logic           protocol_err;

    modport master (
        output reset, add, shift, ready, multiplicand, multiplier,
        input  Q0, product, product_valid, protocol_err
    );

    modport slave (
        input  reset, add, shift, ready, multiplicand, multiplier,
        output Q0, product, product_valid, protocol_err
    );
endinterface

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath (M, C:A, Q) with registered product capture.
// Optional PROTOCOL_CHECK_EN adds a shift counter and a sticky protocol_err.
module mult_datapath #(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           n_rst,
    mult_datapath_if.slave bus
);

    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   a_q, a_d;
    logic           c_q, c_d;
    logic [N-1:0]   q_q, q_d;
    logic [2*N-1:0] product_q, product_d;
    logic           valid_q, valid_d;
    logic           ready_q;
    logic [N:0]     sum;
    logic           ready_rise;

    assign sum        = {1'b0, a_q} + {1'b0, m_q};
    assign ready_rise = bus.ready & ~ready_q;

    // Priority: reset > shift > add > hold
    always_comb begin
        m_d = m_q;
        a_d = a_q;
        c_d = c_q;
        q_d = q_q;
        if (bus.reset) begin
            m_d = bus.multiplicand;
            q_d = bus.multiplier;
            a_d = '0;
            c_d = 1'b0;
        end else if (bus.shift) begin
            a_d = {c_q, a_q[N-1:1]};
            q_d = {a_q[0], q_q[N-1:1]};
            c_d = 1'b0;
        end else if (bus.add) begin
            {c_d, a_d} = sum;
        end
    end

    always_comb begin
        product_d = product_q;
        valid_d   = ready_rise;
        if (ready_rise) begin
            product_d = {a_q, q_q};
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            m_q       <= '0;
            a_q       <= '0;
            c_q       <= 1'b0;
            q_q       <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            c_q       <= c_d;
            q_q       <= q_d;
            product_q <= product_d;
            valid_q   <= valid_d;
            ready_q   <= bus.ready;
        end
    end

    assign bus.Q0            = q_q[0];
    assign bus.product       = product_q;
    assign bus.product_valid = valid_q;

`ifdef PROTOCOL_CHECK_EN
    localparam int CNT_W = $clog2(N + 1) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             cnt_full;

    assign cnt_full = (cnt_q == CNT_W'(N));

    // Counter tracks accepted shifts since the last load; errors latch until n_rst
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (bus.reset) begin
            cnt_d = '0;
        end else if (bus.shift) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((bus.add & bus.shift) ||
            (bus.shift & ~bus.reset & cnt_full) ||
            (ready_rise & ~cnt_full)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.protocol_err = err_q;
`else
    assign bus.protocol_err = 1'b0;
`endif

endmodule
